plab1_imul_mul_arbiter: RTL and testbench
=========================================

# plab1_imul_mul_arbiter

Two-port round-robin arbiter that shares one variable-latency integer multiplier between two requesters tagged by security domain (port 0 = domain 0, port 1 = domain 1). It sits between the two requester val/rdy interfaces and a single multiplier instance. It holds one transaction at a time: grant, issue, wait for the response, release. It drives the multiplier's `domain` input from the registered grant, and zeroes the response data presented to the non-granted port.

## Interface
Parameters:
- `p_msg_nbits`, default 67: request message width (func + a + b).
- `p_res_nbits`, default 32: response message width.

Ports:
- `clk`  in  1: clock. All state updates on rising edge.
- `reset`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req0_val`, `req1_val`  in  1 each: request valid.
- `req0_rdy`, `req1_rdy`  out  1 each: request ready.
- `req0_msg`, `req1_msg`  in  `p_msg_nbits` each: request payload.
- `resp0_val`, `resp1_val`  out  1 each: response valid.
- `resp0_rdy`, `resp1_rdy`  in  1 each: response ready.
- `resp0_msg`, `resp1_msg`  out  `p_res_nbits` each: response payload.
- `mul_in_val`  out  1: multiplier request valid.
- `mul_in_rdy`  in  1: multiplier request ready.
- `mul_in_msg`  out  `p_msg_nbits`: multiplier request payload.
- `mul_out_val`  in  1: multiplier response valid.
- `mul_out_rdy`  out  1: multiplier response ready.
- `mul_out_msg`  in  `p_res_nbits`: multiplier result.
- `mul_domain`  out  1: domain label to the multiplier; equals `grant_reg`.

## Operation
- State registers:
  - `state` ∈ {IDLE, ISSUE, WAIT}.
  - `grant_reg` (1 bit): port currently owning the multiplier.
  - `prio_reg` (1 bit): port favoured on a tie.
- IDLE:
  - All rdy/val outputs are 0; `mul_in_msg` = 0.
  - If any `reqN_val` = 1, load `grant_reg` with the winner and go to ISSUE.
  - Winner is the single requester if only one is valid; if both are valid, the winner is `prio_reg`.
- ISSUE:
  - `mul_in_val` = `req[grant]_val`, `mul_in_msg` = `req[grant]_msg`, `req[grant]_rdy` = `mul_in_rdy`.
  - The non-granted `reqN_rdy` stays 0.
  - When `mul_in_val && mul_in_rdy`, go to WAIT.
- WAIT:
  - `resp[grant]_val` = `mul_out_val`, `resp[grant]_msg` = `mul_out_msg`, `mul_out_rdy` = `resp[grant]_rdy`.
  - The non-granted port sees val = 0 and msg = 0.
  - On `mul_out_val && mul_out_rdy`: go to IDLE and set `prio_reg` = `~grant_reg`.
- Response data outside WAIT, and to the non-granted port at all times, is forced to all-zero. No cross-domain data leaks on the output buses.
- `mul_domain` changes only on the IDLE→ISSUE transition. It is stable for the whole transaction.
- A requester dropping val in ISSUE is a protocol violation. The arbiter stays in ISSUE with `mul_in_val` following `req[grant]_val`; no re-arbitration.
- The multiplier must be reset by the top level concurrently with this block; the arbiter does not flush it.

## Timing
- Reset (asynchronous, while `reset` = 0):
  - `state` = IDLE, `grant_reg` = 0, `prio_reg` = 0.
  - All outputs are 0, including `mul_domain`.
  - Takes effect immediately, mid-transaction included; any in-flight transaction is abandoned.
- Request acceptance latency:
  - A request seen valid in IDLE at edge t is granted at t.
  - `reqN_rdy` can rise in cycle t+1, at the earliest.
- Minimum transaction occupancy: IDLE 1 cycle, ISSUE ≥1 cycle, WAIT ≥1 cycle, plus multiplier latency.
- Back-to-back: after the response handshake at edge t, the next grant is decided at edge t+1 (one IDLE cycle).
- Simultaneous `req0_val` and `req1_val` in IDLE: `prio_reg` wins. The loser waits, holding val.
- Priority rotates only on response completion, not on issue.

## Configuration
- `PLAB1_IMUL_ARB_FIXED_PRIO_EN`:
  - Defined: port 1 always wins ties; `prio_reg` is still maintained but ignored.
  - Undefined: round-robin as above.
  - State machine, zeroing and timing are identical in both builds.

## Test plan
- Single request, port 0, a=3 b=5 → `mul_domain` = 0, `mul_in_msg` = req0, `resp0_msg` = 15 with `resp0_val`; `resp1_msg` = 0 throughout.
- Both ports valid from reset, port0 7×6, port1 9×9:
  - Round-robin: port0 served first (42), then port1 (81).
  - `PLAB1_IMUL_ARB_FIXED_PRIO_EN` build: port1 first.
- Continuous requests on both ports, 6 transactions → grants alternate 0,1,0,1,0,1; `mul_domain` matches each grant and never toggles within a transaction.
- Response backpressure: `resp1_rdy` = 0 for 5 cycles in WAIT → `mul_out_rdy` = 0, state held, `resp1_msg` stable; completes when `resp1_rdy` = 1.
- `reset` pulsed low during WAIT → all outputs 0 in the same cycle; after release, a fresh port1 request is granted with `prio_reg` = 0 semantics.
- Idle check: no requests for 20 cycles → all val/rdy 0, message outputs 0.

Source files
------------

// File: rtl/plab1_imul_mul_arbiter.sv
// Round-robin arbiter sharing one variable-latency multiplier between two security domains.
// Define PLAB1_IMUL_ARB_FIXED_PRIO_EN to make port 1 win every tie.
module plab1_imul_mul_arbiter #(
   parameter int unsigned p_msg_nbits = 67,
   parameter int unsigned p_res_nbits = 32
) (
   input  logic                   clk,
   input  logic                   reset,

   input  logic                   req0_val,
   output logic                   req0_rdy,
   input  logic [p_msg_nbits-1:0] req0_msg,
   input  logic                   req1_val,
   output logic                   req1_rdy,
   input  logic [p_msg_nbits-1:0] req1_msg,

   output logic                   resp0_val,
   input  logic                   resp0_rdy,
   output logic [p_res_nbits-1:0] resp0_msg,
   output logic                   resp1_val,
   input  logic                   resp1_rdy,
   output logic [p_res_nbits-1:0] resp1_msg,

   output logic                   mul_in_val,
   input  logic                   mul_in_rdy,
   output logic [p_msg_nbits-1:0] mul_in_msg,
   input  logic                   mul_out_val,
   output logic                   mul_out_rdy,
   input  logic [p_res_nbits-1:0] mul_out_msg,
   output logic                   mul_domain
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   grant_reg;
   logic   grant_next;
   logic   prio_reg;
   logic   prio_next;
   logic   tie_winner;

`ifdef PLAB1_IMUL_ARB_FIXED_PRIO_EN
   assign tie_winner = 1'b1;
`else
   assign tie_winner = prio_reg;
`endif

   // Domain label follows the registered grant, so it only moves on IDLE->ISSUE.
   assign mul_domain = grant_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         grant_reg <= 1'b0;
         prio_reg  <= 1'b0;
      end else begin
         state     <= state_next;
         grant_reg <= grant_next;
         prio_reg  <= prio_next;
      end
   end

   // Next state and steering; everything not owned by the granted port stays zero.
   always_comb begin
      state_next  = state;
      grant_next  = grant_reg;
      prio_next   = prio_reg;
      req0_rdy    = 1'b0;
      req1_rdy    = 1'b0;
      resp0_val   = 1'b0;
      resp1_val   = 1'b0;
      resp0_msg   = '0;
      resp1_msg   = '0;
      mul_in_val  = 1'b0;
      mul_in_msg  = '0;
      mul_out_rdy = 1'b0;

      case (state)
         ST_IDLE: begin
            if (req0_val || req1_val) begin
               grant_next = (req0_val && req1_val) ? tie_winner : req1_val;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mul_in_val = grant_reg ? req1_val : req0_val;
            mul_in_msg = grant_reg ? req1_msg : req0_msg;
            if (grant_reg) req1_rdy = mul_in_rdy;
            else           req0_rdy = mul_in_rdy;
            if (mul_in_val && mul_in_rdy) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (grant_reg) begin
               resp1_val   = mul_out_val;
               resp1_msg   = mul_out_msg;
               mul_out_rdy = resp1_rdy;
            end else begin
               resp0_val   = mul_out_val;
               resp0_msg   = mul_out_msg;
               mul_out_rdy = resp0_rdy;
            end
            if (mul_out_val && mul_out_rdy) begin
               state_next = ST_IDLE;
               prio_next  = ~grant_reg;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_plab1_imul_mul_arbiter.sv
// Randomized bench for plab1_imul_mul_arbiter against a transaction-level arbiter/multiplier model.
module tb_plab1_imul_mul_arbiter;

   localparam int unsigned MW = 67;
   localparam int unsigned RW = 32;
`ifdef PLAB1_IMUL_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]    rv;
   logic [1:0]    pr;
   logic [MW-1:0] rm [2];
   logic          req0_rdy, req1_rdy, resp0_val, resp1_val;
   logic [RW-1:0] resp0_msg, resp1_msg;
   logic          mul_in_val, mul_in_rdy, mul_out_val, mul_out_rdy, mul_domain;
   logic [MW-1:0] mul_in_msg;
   logic [RW-1:0] mul_out_msg;

   plab1_imul_mul_arbiter #(.p_msg_nbits(MW), .p_res_nbits(RW)) dut (
      .clk(clk), .reset(reset),
      .req0_val(rv[0]), .req0_rdy(req0_rdy), .req0_msg(rm[0]),
      .req1_val(rv[1]), .req1_rdy(req1_rdy), .req1_msg(rm[1]),
      .resp0_val(resp0_val), .resp0_rdy(pr[0]), .resp0_msg(resp0_msg),
      .resp1_val(resp1_val), .resp1_rdy(pr[1]), .resp1_msg(resp1_msg),
      .mul_in_val(mul_in_val), .mul_in_rdy(mul_in_rdy), .mul_in_msg(mul_in_msg),
      .mul_out_val(mul_out_val), .mul_out_rdy(mul_out_rdy), .mul_out_msg(mul_out_msg),
      .mul_domain(mul_domain)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: who owns the multiplier, whether the operand is still to be handed over, who is favoured.
   int  m_phase;   // 0 free, 1 handing operands over, 2 awaiting result
   bit  m_owner;
   bit  m_fav;
   // Requesters: one outstanding operation per port.
   bit            pend [2];
   logic [31:0]   pa [2];
   logic [31:0]   pb [2];
   logic [31:0]   expq0 [$];
   logic [31:0]   expq1 [$];
   int            served [$];
   logic [31:0]   served_res [$];
   // Behavioural multiplier.
   bit            mbusy;
   int            mlat;
   logic [31:0]   mres;
   // Stimulus knobs.
   bit gen_en, always_req, rand_rdy;
   int bp;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ":req0_rdy"},  128'(req0_rdy), 128'(0));
      check({tag, ":req1_rdy"},  128'(req1_rdy), 128'(0));
      check({tag, ":resp0_val"}, 128'(resp0_val), 128'(0));
      check({tag, ":resp1_val"}, 128'(resp1_val), 128'(0));
      check({tag, ":resp0_msg"}, 128'(resp0_msg), 128'(0));
      check({tag, ":resp1_msg"}, 128'(resp1_msg), 128'(0));
      check({tag, ":mul_in_val"}, 128'(mul_in_val), 128'(0));
      check({tag, ":mul_in_msg"}, 128'(mul_in_msg), 128'(0));
      check({tag, ":mul_out_rdy"}, 128'(mul_out_rdy), 128'(0));
      check({tag, ":mul_domain"}, 128'(mul_domain), 128'(0));
   endtask

   task automatic new_op(input int p, input logic [31:0] a, input logic [31:0] b);
      pend[p] = 1'b1;
      pa[p]   = a;
      pb[p]   = b;
   endtask

   // One clock of stimulus, output comparison against the model, and model update.
   task automatic step();
      logic          e_in_val, e_out_rdy;
      logic [MW-1:0] e_in_msg;
      logic [1:0]    e_rr, e_pv;
      logic [RW-1:0] e_pm [2];
      logic [RW-1:0] got, exp_res;
      bit            in_fire, out_fire;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         if (!pend[p] && (always_req || (gen_en && $urandom_range(0, 3) == 0)))
            new_op(p, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15),
                      $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15));
         rv[p] = pend[p];
         rm[p] = pend[p] ? {3'd0, pa[p], pb[p]} : MW'({$urandom, $urandom, $urandom});
         pr[p] = (bp > 0) ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      mul_in_rdy  = !mbusy && (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      mul_out_val = mbusy && (mlat == 0);
      mul_out_msg = mul_out_val ? mres : $urandom;
      #1;
      e_in_val = 1'b0; e_in_msg = '0; e_out_rdy = 1'b0;
      e_rr = 2'b00; e_pv = 2'b00; e_pm[0] = '0; e_pm[1] = '0;
      if (m_phase == 1) begin
         e_in_val       = rv[m_owner];
         e_in_msg       = rm[m_owner];
         e_rr[m_owner]  = mul_in_rdy;
      end else if (m_phase == 2) begin
         e_pv[m_owner]  = mul_out_val;
         e_pm[m_owner]  = mul_out_msg;
         e_out_rdy      = pr[m_owner];
      end
      check("req0_rdy",    128'(req0_rdy),    128'(e_rr[0]));
      check("req1_rdy",    128'(req1_rdy),    128'(e_rr[1]));
      check("resp0_val",   128'(resp0_val),   128'(e_pv[0]));
      check("resp1_val",   128'(resp1_val),   128'(e_pv[1]));
      check("resp0_msg",   128'(resp0_msg),   128'(e_pm[0]));
      check("resp1_msg",   128'(resp1_msg),   128'(e_pm[1]));
      check("mul_in_val",  128'(mul_in_val),  128'(e_in_val));
      check("mul_in_msg",  128'(mul_in_msg),  128'(e_in_msg));
      check("mul_out_rdy", 128'(mul_out_rdy), 128'(e_out_rdy));
      check("mul_domain",  128'(mul_domain),  128'(m_owner));

      in_fire  = e_in_val && mul_in_rdy;
      out_fire = e_out_rdy && mul_out_val;
      if (m_phase == 2 && bp > 0) bp--;

      if (m_phase == 0) begin
         if (rv[0] && rv[1]) begin
            m_owner = FIXED ? 1'b1 : m_fav;
            m_phase = 1;
         end else if (rv[0] || rv[1]) begin
            m_owner = rv[1];
            m_phase = 1;
         end
      end else if (m_phase == 1 && in_fire) begin
         pend[m_owner] = 1'b0;
         if (m_owner) expq1.push_back(pa[1] * pb[1]);
         else         expq0.push_back(pa[0] * pb[0]);
         m_phase = 2;
      end else if (m_phase == 2 && out_fire) begin
         got = m_owner ? resp1_msg : resp0_msg;
         check("resp_expected", 128'(m_owner ? (expq1.size() > 0) : (expq0.size() > 0)), 128'(1));
         exp_res = m_owner ? expq1.pop_front() : expq0.pop_front();
         check("resp_data", 128'(got), 128'(exp_res));
         served.push_back(int'(m_owner));
         served_res.push_back(got);
         m_fav   = ~m_owner;
         m_phase = 0;
      end

      if (out_fire) mbusy = 1'b0;
      if (in_fire) begin
         mbusy = 1'b1;
         mlat  = rand_rdy ? int'($urandom_range(0, 3)) : 0;
         mres  = e_in_msg[63:32] * e_in_msg[31:0];
      end else if (mbusy && mlat > 0) begin
         mlat--;
      end
   endtask

   // Async reset applied wherever the clock is; outputs must clear immediately.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      check_zero(tag);
      pend[0] = 1'b0; pend[1] = 1'b0;
      rv = 2'b00; pr = 2'b00; rm[0] = '0; rm[1] = '0;
      mul_in_rdy = 1'b0; mul_out_val = 1'b0; mul_out_msg = '0;
      mbusy = 1'b0; mlat = 0; mres = '0;
      m_phase = 0; m_owner = 1'b0; m_fav = 1'b0; bp = 0;
      expq0.delete(); expq1.delete(); served.delete(); served_res.delete();
      gen_en = 1'b0; always_req = 1'b0; rand_rdy = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drain(input int maxc);
      int c = 0;
      while ((pend[0] || pend[1] || m_phase != 0) && c < maxc) begin
         step();
         c++;
      end
      check("drain_in_budget", 128'(c < maxc), 128'(1));
   endtask

   initial begin
      int c;
      reset = 1'b0;
      do_reset("reset");

      // Single port-0 request 3x5.
      new_op(0, 32'd3, 32'd5);
      drain(50);
      check("t1_count",  128'(served.size()), 128'(1));
      check("t1_result", 128'(served_res[0]), 128'(15));

      // Both valid out of reset.
      do_reset("reset2");
      new_op(0, 32'd7, 32'd6);
      new_op(1, 32'd9, 32'd9);
      drain(50);
      check("t2_count",  128'(served.size()), 128'(2));
      check("t2_first",  128'(served[0]), 128'(FIXED ? 1 : 0));
      check("t2_res0",   128'(served_res[0]), 128'(FIXED ? 81 : 42));
      check("t2_res1",   128'(served_res[1]), 128'(FIXED ? 42 : 81));

      // Continuous requests on both ports: grants rotate.
      do_reset("reset3");
      always_req = 1'b1;
      c = 0;
      while (served.size() < 6 && c < 200) begin step(); c++; end
      check("t3_in_budget", 128'(c < 200), 128'(1));
      for (int i = 0; i < 6; i++)
         check($sformatf("t3_grant%0d", i), 128'(served[i]), 128'(FIXED ? 1 : (i % 2)));
      always_req = 1'b0;
      drain(100);

      // Response backpressure on port 1.
      do_reset("reset4");
      new_op(1, 32'd12, 32'd11);
      bp = 5;
      drain(50);
      check("t4_result", 128'(served_res[0]), 128'(132));

      // Reset during WAIT with port 1 owning the multiplier.
      do_reset("reset5");
      new_op(0, 32'd2, 32'd2);
      drain(50);
      new_op(1, 32'd4, 32'd4);
      c = 0;
      while (m_phase != 2 && c < 50) begin step(); c++; end
      check("t5_reach_wait", 128'(m_phase), 128'(2));
      @(posedge clk);
      #1;
      do_reset("reset_mid_wait");
      new_op(0, 32'd5, 32'd5);
      new_op(1, 32'd6, 32'd6);
      drain(50);
      check("t5_first", 128'(served[0]), 128'(FIXED ? 1 : 0));
      served.delete();
      new_op(1, 32'd8, 32'd3);
      drain(50);
      check("t5_port1_only", 128'(served[0]), 128'(1));

      // Idle stretch.
      repeat (20) step();

      // Randomized traffic with random readiness and latency.
      gen_en = 1'b1; rand_rdy = 1'b1;
      served.delete();
      repeat (1500) step();
      gen_en = 1'b0;
      drain(300);
      check("rand_progress", 128'(served.size() > 10), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
